// File: rtl/tdm_mux_4x1_if.sv
// tdm_mux_4x1_if: bundle of the four producer channels and the shared
// output link of the 4:1 TDM multiplexer.
//   In0..In3  channel data          V0..V3    channel word valid
//   R0..R3    channel ready         Out       multiplexed data
//   S1,S0     channel tag of Out    Out_valid Out/S1/S0 hold a word
//   Out_ready downstream accepts the word
// Modports: slave = the multiplexer, master = producers + downstream link.
interface tdm_mux_4x1_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] In0;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [WIDTH-1:0] In3;
  logic             V0;
  logic             V1;
  logic             V2;
  logic             V3;
  logic             R0;
  logic             R1;
  logic             R2;
  logic             R3;
  logic [WIDTH-1:0] Out;
  logic             S0;
  logic             S1;
  logic             Out_valid;
  logic             Out_ready;

  modport slave (
    input  In0, In1, In2, In3,
    input  V0, V1, V2, V3,
    output R0, R1, R2, R3,
    output Out, S0, S1, Out_valid,
    input  Out_ready
  );

  modport master (
    output In0, In1, In2, In3,
    output V0, V1, V2, V3,
    input  R0, R1, R2, R3,
    input  Out, S0, S1, Out_valid,
    output Out_ready
  );
endinterface

// File: rtl/tdm_mux_4x1.sv
// tdm_mux_4x1: four-channel time-division multiplexer. Each channel has a
// one-word holding buffer; loaded buffers are granted onto a single
// registered output bus tagged with the channel index {S1,S0}, which steers
// the downstream 1:4 demultiplexer.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  tdm_mux_4x1_if.slave (In0..In3, V0..V3, R0..R3, Out, S1, S0,
//        Out_valid, Out_ready)
// Build option: define TDM_MUX_FIXED_PRI_EN for strict priority
// (channel 0 highest); default is round-robin after the last grant.
module tdm_mux_4x1 #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  tdm_mux_4x1_if.slave bus
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned IDXW = 2;
`ifndef TDM_MUX_FIXED_PRI_EN
  localparam logic [IDXW-1:0] LAST_RST = 2'd3;
`endif

  // Channel inputs gathered into arrays
  logic [WIDTH-1:0] in_data [NCH];
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   ready_c;

  assign in_data[0] = bus.In0;
  assign in_data[1] = bus.In1;
  assign in_data[2] = bus.In2;
  assign in_data[3] = bus.In3;
  assign in_valid   = {bus.V3, bus.V2, bus.V1, bus.V0};

  // State
  logic [NCH-1:0]   full_q,  full_d;
  logic [WIDTH-1:0] buf_q [NCH];
  logic [WIDTH-1:0] buf_d [NCH];
  logic [WIDTH-1:0] out_q, out_d;
  logic [IDXW-1:0]  tag_q, tag_d;
  logic             valid_q, valid_d;
`ifndef TDM_MUX_FIXED_PRI_EN
  logic [IDXW-1:0]  last_q, last_d;
  logic [IDXW-1:0]  cand_c;
`endif

  logic             out_free_c;
  logic             grant_found_c;
  logic [IDXW-1:0]  grant_idx_c;

  // A full buffer cannot refill, so accept and drain never collide
  assign ready_c    = ~full_q & {NCH{~rst}};
  assign out_free_c = ~valid_q | bus.Out_ready;

  // Arbiter: scan from lowest to highest priority so the last hit wins
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
`ifdef TDM_MUX_FIXED_PRI_EN
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (full_q[i]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = IDXW'(i);
      end
    end
`else
    cand_c = '0;
    // Priority order is L+1, L+2, L+3, L; L+4 wraps to L
    for (int i = int'(NCH); i >= 1; i--) begin
      cand_c = last_q + IDXW'(i);
      if (full_q[cand_c]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
`endif
  end

  // Next-state: drain into the output register, then capture accepted words
  always_comb begin
    full_d  = full_q;
    buf_d   = buf_q;
    out_d   = out_q;
    tag_d   = tag_q;
    valid_d = valid_q;
`ifndef TDM_MUX_FIXED_PRI_EN
    last_d  = last_q;
`endif

    if (out_free_c) begin
      if (grant_found_c) begin
        out_d                = buf_q[grant_idx_c];
        tag_d                = grant_idx_c;
        valid_d              = 1'b1;
        full_d[grant_idx_c]  = 1'b0;
`ifndef TDM_MUX_FIXED_PRI_EN
        last_d               = grant_idx_c;
`endif
      end else begin
        // Out and tag keep their last values when idle
        valid_d = 1'b0;
      end
    end

    for (int i = 0; i < int'(NCH); i++) begin
      if (in_valid[i] && ready_c[i]) begin
        full_d[i] = 1'b1;
        buf_d[i]  = in_data[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= '0;
      out_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
`ifndef TDM_MUX_FIXED_PRI_EN
      last_q  <= LAST_RST;
`endif
      for (int i = 0; i < int'(NCH); i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      full_q  <= full_d;
      out_q   <= out_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
`ifndef TDM_MUX_FIXED_PRI_EN
      last_q  <= last_d;
`endif
      for (int i = 0; i < int'(NCH); i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Outputs
  assign bus.Out       = out_q;
  assign bus.S0        = tag_q[0];
  assign bus.S1        = tag_q[1];
  assign bus.Out_valid = valid_q;
  assign bus.R0        = ready_c[0];
  assign bus.R1        = ready_c[1];
  assign bus.R2        = ready_c[2];
  assign bus.R3        = ready_c[3];

endmodule

// File: tb/tb_tdm_mux_4x1.sv
// Testbench for tdm_mux_4x1: directed scenarios followed by random stress,
// checked against a behavioural channel/arbiter model, a per-tag in-order
// scoreboard and (round-robin build) a 3-grant fairness bound.
module tb_tdm_mux_4x1;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_mux_4x1_if #(.WIDTH(WIDTH)) bus ();
  tdm_mux_4x1 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [WIDTH-1:0] din [4];
  logic [3:0]       vin;
  logic             oready;

  assign bus.In0       = din[0];
  assign bus.In1       = din[1];
  assign bus.In2       = din[2];
  assign bus.In3       = din[3];
  assign bus.V0        = vin[0];
  assign bus.V1        = vin[1];
  assign bus.V2        = vin[2];
  assign bus.V3        = vin[3];
  assign bus.Out_ready = oready;

  wire [3:0] rdy = {bus.R3, bus.R2, bus.R1, bus.R0};
  wire [1:0] tag = {bus.S1, bus.S0};

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit   [3:0]       m_full;
  logic [WIDTH-1:0] m_buf [4];
  logic [WIDTH-1:0] m_out;
  int               m_tag;
  bit               m_valid;
  int               m_last;
  logic [WIDTH-1:0] sbq [4][$];
  int               wait_cnt [4];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full  = '0;
    m_valid = 1'b0;
    m_out   = '0;
    m_tag   = 0;
    m_last  = 3;
    for (int i = 0; i < 4; i++) begin
      m_buf[i] = '0;
      sbq[i].delete();
      wait_cnt[i] = 0;
    end
  endtask

  // One clock: update model/scoreboard from pre-edge values, then compare
  task automatic tick();
    bit         pre_free;
    logic [3:0] pre_rdy;
    bit   [3:0] acc;
    int         k;
    int         t;
    int         c;
    logic [WIDTH-1:0] w;

    pre_free = !bus.Out_valid || oready;
    pre_rdy  = rdy;

    // Scoreboard: word consumed by downstream on this edge
    if (!rst && bus.Out_valid === 1'b1 && oready) begin
      t = int'(tag);
      chk("sb_word_expected", 32'(sbq[t].size() != 0), 32'd1);
      if (sbq[t].size() != 0) begin
        w = sbq[t].pop_front();
        chk("sb_in_order", 32'(bus.Out), 32'(w));
      end
    end

    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) acc[i] = vin[i] && !m_full[i];
      if (!m_valid || oready) begin
        k = -1;
`ifdef TDM_MUX_FIXED_PRI_EN
        for (int j = 0; j < 4; j++) if (k < 0 && m_full[j]) k = j;
`else
        for (int j = 1; j <= 4; j++) begin
          c = (m_last + j) % 4;
          if (k < 0 && m_full[c]) k = c;
        end
`endif
        if (k >= 0) begin
          m_out     = m_buf[k];
          m_tag     = k;
          m_valid   = 1'b1;
          m_full[k] = 1'b0;
          m_last    = k;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          m_full[i] = 1'b1;
          m_buf[i]  = din[i];
          sbq[i].push_back(din[i]);
        end
      end
    end

    @(posedge clk);
    #1;

    // Fairness measured on the DUT: grants seen while a channel sat full
    if (!rst && pre_free && bus.Out_valid === 1'b1) begin
      t = int'(tag);
      for (int j = 0; j < 4; j++) if (j != t && pre_rdy[j] === 1'b0) wait_cnt[j]++;
`ifndef TDM_MUX_FIXED_PRI_EN
      chk("fairness", 32'(wait_cnt[t] <= 3), 32'd1);
`endif
      wait_cnt[t] = 0;
    end

    chk("model_out_valid", 32'(bus.Out_valid), 32'(m_valid));
    chk("model_out", 32'(bus.Out), 32'(m_out));
    chk("model_tag", 32'(tag), 32'(m_tag));
    chk("model_ready", 32'(rdy), 32'(~m_full & {4{~rst}}));
  endtask

  logic [WIDTH-1:0] exp_all [4];

  initial begin
    rst    = 1'b1;
    vin    = '0;
    oready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = '0;
    model_reset();

    // Reset, valids ignored while rst is high
    vin = 4'hF;
    tick();
    tick();
    chk("rst_ready_low", 32'(rdy), 32'h0);
    chk("rst_out", 32'(bus.Out), 32'h0);
    vin = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(rdy), 32'hF);
    chk("post_rst_valid", 32'(bus.Out_valid), 32'h0);
    chk("post_rst_tag", 32'(tag), 32'h0);

    // Single word on channel 2
    din[2] = 8'hA5;
    vin    = 4'b0100;
    tick();
    vin = '0;
    chk("single_not_yet", 32'(bus.Out_valid), 32'h0);
    tick();
    chk("single_out", 32'(bus.Out), 32'hA5);
    chk("single_tag", 32'(tag), 32'h2);
    chk("single_valid", 32'(bus.Out_valid), 32'h1);
    tick();
    chk("single_one_cycle", 32'(bus.Out_valid), 32'h0);

    // All channels loaded together after reset (L = 3)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_all = '{8'h10, 8'h21, 8'h32, 8'h43};
    for (int i = 0; i < 4; i++) din[i] = exp_all[i];
    vin = 4'hF;
    tick();
    vin = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("all_out", 32'(bus.Out), 32'(exp_all[i]));
      chk("all_tag", 32'(tag), 32'(i));
      chk("all_valid", 32'(bus.Out_valid), 32'h1);
    end
    tick();
    chk("all_done", 32'(bus.Out_valid), 32'h0);

    // Backpressure with channels 1 and 3 loaded behind a stalled word
    oready = 1'b0;
    din[0] = 8'h55;
    vin    = 4'b0001;
    tick();
    vin = '0;
    tick();
    din[1] = 8'h66;
    din[3] = 8'h77;
    vin    = 4'b1010;
    tick();
    vin = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_frozen", 32'(bus.Out), 32'h55);
      chk("bp_tag_frozen", 32'(tag), 32'h0);
      chk("bp_valid_frozen", 32'(bus.Out_valid), 32'h1);
      chk("bp_r1_r3_low", 32'({rdy[3], rdy[1]}), 32'h0);
    end
    oready = 1'b1;
    tick();
    chk("bp_rel_out1", 32'(bus.Out), 32'h66);
    chk("bp_rel_tag1", 32'(tag), 32'h1);
    tick();
    chk("bp_rel_out3", 32'(bus.Out), 32'h77);
    chk("bp_rel_tag3", 32'(tag), 32'h3);
    tick();
    chk("bp_rel_done", 32'(bus.Out_valid), 32'h0);

    // Reset mid-operation: stalled word plus two full buffers are discarded
    oready = 1'b0;
    din[0] = 8'h99;
    vin    = 4'b0001;
    tick();
    vin = '0;
    tick();
    din[1] = 8'hAA;
    din[2] = 8'hBB;
    vin    = 4'b0110;
    tick();
    vin = '0;
    chk("mid_valid_before", 32'(bus.Out_valid), 32'h1);
    chk("mid_full_before", 32'(rdy[2:1]), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_valid_after", 32'(bus.Out_valid), 32'h0);
    chk("mid_out_after", 32'(bus.Out), 32'h0);
    chk("mid_ready_after", 32'(rdy), 32'hF);
    oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_ghost", 32'(bus.Out_valid), 32'h0);
    end

    // Random stress
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) din[i] = WIDTH'($urandom);
      vin    = 4'($urandom);
      oready = ($urandom_range(3) != 0);
      rst    = ($urandom_range(499) == 0);
      tick();
    end
    rst    = 1'b0;
    vin    = '0;
    oready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 4; i++) chk("drain_empty", 32'(sbq[i].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
